// File: rtl/timer_apb_arb2.sv
// Two-master APB arbiter in front of the timer register slave.
// Grants one master per transfer, runs SETUP/ACCESS, times out hung slaves.
//
// Ports:
//   pclk, presetn            clock, async active-low reset
//   m0_*, m1_*               master-side APB (psel/penable/pwrite/paddr/pwdata in,
//                            prdata/pready/pslverr out, pready is a 1-cycle pulse)
//   psel..pwdata (out)       slave-side request, stable SETUP through ACCESS
//   prdata/pready/pslverr    slave-side response
module timer_apb_arb2 #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RR      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_COMPLETE
  } state_t;

  localparam bit RR_EN = (RR != 0);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state;
  logic                r_last;
  logic                r_grant;
  logic [CW-1:0]       r_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [1:0]          r_ready;
  logic [1:0]          r_err;
  logic [1:0][DATA_W-1:0] r_rdata;

  logic                w_any;
  logic                w_both;
  logic                w_only1;
  logic                w_pick1;
  logic                w_wr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_to;
  logic [DATA_W-1:0]   w_cap;

  // penable from the masters carries no arbitration information
  logic w_unused;
  assign w_unused = &{1'b0, m0_penable, m1_penable};

  assign w_any   = m0_psel | m1_psel;
  assign w_both  = m0_psel & m1_psel;
  assign w_only1 = m1_psel & ~m0_psel;

  // r_last holds the index of the previous grant; on a tie
  // round-robin picks the other one
  always_comb begin
    w_pick1 = 1'b0;
    unique case (1'b1)
      w_both:  w_pick1 = RR_EN ? ~r_last : 1'b0;
      w_only1: w_pick1 = 1'b1;
      default: w_pick1 = 1'b0;
    endcase
  end

  assign w_wr    = w_pick1 ? m1_pwrite : m0_pwrite;
  assign w_addr  = w_pick1 ? m1_paddr  : m0_paddr;
  assign w_wdata = w_pick1 ? m1_pwdata : m0_pwdata;

  assign w_to  = TO_EN && (r_cnt == TO_LAST);
  assign w_cap = r_pwrite ? '0 : prdata;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_ready   <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_pick1;
            r_last   <= w_pick1;
            r_pwrite <= w_wr;
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_ready[r_grant] <= 1'b1;
            r_err[r_grant]   <= pslverr;
            r_rdata[r_grant] <= w_cap;
            r_state          <= S_COMPLETE;
          end else if (w_to) begin
            // slave hung: abandon the access, report an error
            r_psel           <= 1'b0;
            r_penable        <= 1'b0;
            r_ready[r_grant] <= 1'b1;
            r_err[r_grant]   <= 1'b1;
            r_rdata[r_grant] <= '0;
            r_state          <= S_COMPLETE;
          end else if (TO_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COMPLETE: begin
          r_ready <= '0;
          r_err   <= '0;
          r_rdata <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign m0_pready  = r_ready[0];
  assign m0_pslverr = r_err[0];
  assign m0_prdata  = r_rdata[0];
  assign m1_pready  = r_ready[1];
  assign m1_pslverr = r_err[1];
  assign m1_prdata  = r_rdata[1];

endmodule
